// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative shift-add multiplier / restoring divider.
// One bit per cycle; Busy stalls the pipeline from the Start cycle on.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int W2 = 2 * WIDTH;

  typedef enum logic {
    IDLE,
    COMPUTING
  } state_t;

  state_t state_q, state_d;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] cst_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] orig_q;
  logic             neg_q;
  logic             negr_q;
  logic             divz_q;
  logic [CW-1:0]    cnt_q;
  logic [W2-1:0]    acc_q;

  logic             launch;
  logic             done;

  // operand capture
  logic             sgn;
  logic             is_div;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] cst_d;
  logic [WIDTH-1:0] sh_d;

  assign sgn    = ~MCycleOp[0];
  assign is_div = MCycleOp[1];
  assign a_abs  = (sgn && Operand1[WIDTH-1]) ? -Operand1 : Operand1;
  assign b_abs  = (sgn && Operand2[WIDTH-1]) ? -Operand2 : Operand2;
  assign cst_d  = is_div ? b_abs : a_abs;
  assign sh_d   = is_div ? a_abs : b_abs;

  // one iteration of either algorithm
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   madd;
  logic [W2-1:0]    mul_nx;
  logic [WIDTH:0]   shrem;
  logic [WIDTH:0]   diff;
  logic             qb;
  logic [WIDTH-1:0] rem_nx;
  logic [W2-1:0]    div_nx;
  logic [W2-1:0]    acc_nx;
  logic [WIDTH-1:0] sh_nx;

  assign hi     = acc_q[W2-1:WIDTH];
  assign lo     = acc_q[WIDTH-1:0];
  assign addend = sh_q[0] ? cst_q : '0;
  assign madd   = {1'b0, hi} + {1'b0, addend};
  assign mul_nx = {madd, lo[WIDTH-1:1]};

  // remainder stays below the divisor, so a borrow out of bit WIDTH
  // means the trial subtraction failed
  assign shrem  = {hi, sh_q[WIDTH-1]};
  assign diff   = shrem - {1'b0, cst_q};
  assign qb     = ~diff[WIDTH];
  assign rem_nx = qb ? diff[WIDTH-1:0] : shrem[WIDTH-1:0];
  assign div_nx = {rem_nx, lo[WIDTH-2:0], qb};

  assign acc_nx = op_q[1] ? div_nx : mul_nx;
  assign sh_nx  = op_q[1] ? (sh_q << 1) : (sh_q >> 1);

  // sign fix-up of the final iteration
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] r1_d;
  logic [WIDTH-1:0] r2_d;

  assign prod = neg_q ? -acc_nx : acc_nx;
  assign quo  = neg_q ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];
  assign rem  = negr_q ? -acc_nx[W2-1:WIDTH] : acc_nx[W2-1:WIDTH];

  always_comb begin
    r1_d = prod[WIDTH-1:0];
    r2_d = prod[W2-1:WIDTH];
    if (op_q[1]) begin
      if (divz_q) begin
        r1_d = '1;
        r2_d = orig_q;
      end else begin
        r1_d = quo;
        r2_d = rem;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    done    = 1'b0;
    Busy    = 1'b0;
    unique case (state_q)
      IDLE: begin
        Busy = Start;
        if (Start) begin
          launch  = 1'b1;
          state_d = COMPUTING;
        end
      end
      COMPUTING: begin
        Busy = 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      op_q    <= '0;
      cst_q   <= '0;
      sh_q    <= '0;
      orig_q  <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      divz_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      Result1 <= '0;
      Result2 <= '0;
    end else if (launch) begin
      op_q   <= MCycleOp;
      cst_q  <= cst_d;
      sh_q   <= sh_d;
      orig_q <= Operand1;
      neg_q  <= sgn & (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
      negr_q <= sgn & Operand1[WIDTH-1];
      divz_q <= (Operand2 == '0);
      cnt_q  <= '0;
      acc_q  <= '0;
    end else if (state_q == COMPUTING) begin
      acc_q <= acc_nx;
      sh_q  <= sh_nx;
      cnt_q <= cnt_q + CW'(1);
      if (done) begin
        Result1 <= r1_d;
        Result2 <= r2_d;
      end
    end
  end

endmodule

// File: doc/mcycle_unit.md
Name: mcycle_unit

Overview:
- Iterative multi-cycle multiply/divide unit that sits directly downstream of the control unit.
- The decoder raises Start and MCycleOp for MUL/DIV-class instructions. This block computes over WIDTH cycles and drives Busy back to stall the PC and register write.
- The datapath takes Result1/Result2 into the write-back mux once Busy falls.

Parameters:
WIDTH, 32, operand and result width in bits (>= 4)

Ports:
CLK  input  1  system clock, rising edge
RESET_N  input  1  asynchronous active-low reset
Start  input  1  request a new operation (from decoder)
MCycleOp  input  2  00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div
Operand1  input  WIDTH  multiplicand / dividend
Operand2  input  WIDTH  multiplier / divisor
Result1  output  WIDTH  product low half / quotient
Result2  output  WIDTH  product high half / remainder
Busy  output  1  operation in progress; stall request to pipeline/PC

Behaviour:
- Reset: async on RESET_N low. State=IDLE, counter=0, Result1=0, Result2=0, Busy=0. Reset mid-operation aborts it; results do not update.
- States: IDLE, COMPUTING.
- Busy is combinational: (state==COMPUTING) | (state==IDLE & Start). This lets the stall apply in the same cycle Start is raised.
- IDLE with Start=1 at edge k:
  - latch MCycleOp;
  - latch operand magnitudes (two's-complement abs when op is signed);
  - latch result-sign flags;
  - clear the accumulator, set counter=0, go to COMPUTING.
- COMPUTING: one iteration per edge.
  - Multiply: shift-add, one multiplier bit per cycle into a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
- Completion: on edge k+WIDTH (counter==WIDTH-1):
  - apply sign fix-up;
  - register Result1/Result2;
  - return to IDLE.
  - Busy is therefore high for WIDTH+1 cycles, including the Start cycle.
- Results hold their value from the last completed operation until the next completion. They never show intermediate values.
- Start while COMPUTING is ignored. Operand/MCycleOp changes after edge k are ignored.
- Start held high continuously: a new operation launches on the edge immediately after completion (back-to-back, no idle gap).
- Signed multiply: product negated if operand signs differ. Full 2*WIDTH result, {Result2,Result1}.
- Signed divide: quotient negated if signs differ. Remainder takes the dividend's sign (truncating division).
- Unsigned ops: no fix-up.
- Divide by zero (Operand2==0), any divide op:
  - Result1 = all ones;
  - Result2 = Operand1 as latched (original signed value);
  - same latency.
- Signed overflow (most-negative / -1): Result1 = most-negative value (wraps), Result2 = 0.
- All arithmetic is modulo 2^WIDTH per result word. No X on outputs after reset.

Test Plan:
1. Reset then idle: RESET_N low 3 cycles, release, Start=0 -> Busy=0, Result1=Result2=0x00000000 indefinitely.
2. Unsigned mul: Start=1 one cycle, MCycleOp=01, Operand1=0xFFFFFFFF, Operand2=0x00000002.
   - Busy high 33 cycles.
   - Then Result2=0x00000001, Result1=0xFFFFFFFE.
   - Results unchanged while Busy.
3. Signed mul and signed div:
   - MCycleOp=00, Operand1=-7 (0xFFFFFFF9), Operand2=6 -> Result1=0xFFFFFFD6 (-42), Result2=0xFFFFFFFF.
   - Next, MCycleOp=10, Operand1=-7, Operand2=2 -> Result1=0xFFFFFFFD (-3), Result2=0xFFFFFFFF (-1).
4. Division corner cases:
   - MCycleOp=11, Operand1=100, Operand2=0 -> Result1=0xFFFFFFFF, Result2=0x00000064.
   - MCycleOp=10, Operand1=0x80000000, Operand2=0xFFFFFFFF -> Result1=0x80000000, Result2=0.
5. Start ignored while busy: launch unsigned div 100/7. At cycle 10 pulse Start with mul 3*3 -> results 14/2 only, Busy falls at cycle 33.
6. Reset mid-operation: launch mul 5*5, assert RESET_N low at cycle 15.
   - Busy drops immediately; results stay 0.
   - After release, a fresh 4*4 gives Result1=16 with full 33-cycle latency.
